// File: rtl/rx_pkg.sv
// Shared types and constants for the UART receive bit timer.
package rx_pkg;

  // Receive sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    DONE  = 2'd3
  } rx_state_t;

  // Level of an idle UART line; also the reset value of every synchronizer stage
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/rx_edge_sync.sv
// Two-flop synchronizer for the raw serial line plus falling-edge detection
// on the synchronized value. All stages reset to the idle line level so that
// releasing reset never produces a spurious edge.
module rx_edge_sync
  import rx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic serial_out,
  output logic fall_edge
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next-state values: shift the line through the synchronizer and edge history
  always_comb begin
    sync1_d = serial_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and edge-history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      prev_q  <= IDLE_LEVEL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign serial_out = sync2_q;
  assign fall_edge  = prev_q & ~sync2_q;

endmodule

// File: rtl/rx_bit_timer.sv
// UART receive front end: qualifies the start bit, then issues one mid-bit
// shift strobe per data/stop bit for the downstream shift register, pulses
// packet_done after the stop bit and records a low stop bit as a framing error.
module rx_bit_timer
  import rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BITS     = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic serial_in,
  output logic serial_out,
  output logic shift_strobe,
  output logic packet_done,
  output logic framing_error,
  output logic busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(NUM_BITS + 1);

  // clk_cnt value in START on the cycle the start bit is at its middle
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  // clk_cnt value on the cycle before a strobe; the strobe flop fires next cycle
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  // clk_cnt value on a strobe cycle; counter wraps here
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic sync_serial_s;
  logic fall_edge_s;

  rx_state_t        state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             strobe_q,  strobe_d;
  logic             done_q,    done_d;
  logic             ferr_q,    ferr_d;
  logic             busy_q,    busy_d;

  rx_edge_sync u_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .serial_out (sync_serial_s),
    .fall_edge  (fall_edge_s)
  );

  // Sequencer next state, counters and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    ferr_d    = ferr_q;
    case (state_q)
      IDLE: begin
        clk_cnt_d = CNT_ZERO;
        if (fall_edge_s) begin
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = CNT_ZERO;
          if (sync_serial_s == 1'b0) begin
            // Line still low at mid start bit: a real frame begins
            state_d   = DATA;
            bit_cnt_d = BIT_ZERO;
            ferr_d    = 1'b0;
          end else begin
            // Line back high: glitch, abandon without touching framing_error
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_LAST) begin
          // This cycle carries a strobe; account for the bit just sampled
          clk_cnt_d = CNT_ZERO;
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = DONE;
            done_d  = 1'b1;
            ferr_d  = ~sync_serial_s;
          end else begin
            state_d = DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
          if (clk_cnt_q == CNT_PRE) begin
            strobe_d = 1'b1;
          end else begin
            strobe_d = 1'b0;
          end
        end
      end
      DONE: begin
        clk_cnt_d = CNT_ZERO;
        state_d   = IDLE;
      end
      default: begin
        clk_cnt_d = CNT_ZERO;
        bit_cnt_d = BIT_ZERO;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= CNT_ZERO;
      bit_cnt_q <= BIT_ZERO;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      busy_q    <= busy_d;
    end
  end

  assign serial_out    = sync_serial_s;
  assign shift_strobe  = strobe_q;
  assign packet_done   = done_q;
  assign framing_error = ferr_q;
  assign busy          = busy_q;

endmodule
